multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Parametrised multi-cycle control FSM, successor to the single-cycle opcode decoder in the datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the ALU control and datapath select bus per state, waits on a memory ready handshake, defers halt to instruction boundaries, traps illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
OPC_W, 4, opcode width; opcodes with bits above [3:0] non-zero are illegal
ALU_W, 3, alu_cont width; decoded codes zero-extended to ALU_W
SEL_W, 6, datapath select width; decoded codes zero-extended to SEL_W
TMO_W, 4, memory-wait timeout counter width; timeout after 2**TMO_W-1 wait cycles
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
opr  in  OPC_W  opcode from instruction register, valid in DECODE
halt  in  1  halt request level
mem_ready  in  1  memory completion, sampled in MEM
alu_cont  out  ALU_W  ALU operation code
s  out  SEL_W  datapath select bus
ir_load  out  1  load instruction register
pc_inc  out  1  advance PC
pc_load  out  1  load jump target into PC
mem_req  out  1  memory request, held for the whole MEM state
reg_we  out  1  register-file write enable
halted  out  1  in HALTED state
trap  out  1  in TRAP state (sticky)
trap_cause  out  2  cause: 00 none, 01 illegal opcode, 10 memory timeout
instr_cnt  out  CNT_W  retired-instruction count, wraps

Behaviour:
- All outputs are registered Moore outputs decoded from state plus latched decode fields. There are no combinational paths from inputs to outputs.
- Reset, on the rising edge with rst=1, overrides everything, including mid-instruction and TRAP:
  - state = FETCH
  - all outputs 0, instr_cnt = 0, trap_cause = 00, timeout counter = 0
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED, TRAP.
- FETCH:
  - if halt=1: go to HALTED; no ir_load or pc_inc
  - else: ir_load=1 and pc_inc=1 for one cycle, then DECODE
- HALTED: halted=1, all strobes 0. Stay while halt=1; on halt=0 go to FETCH.
- DECODE:
  - latch alu_code and s_code from opr; all strobes 0
  - the decode table lives in the package (opcode: alu, s, class):
    - 0000: 100, 000100, R
    - 0001: 011, 001000, R
    - 0010: 000, 000100, R
    - 0011: 001, 000100, R
    - 1000: 011, 100011, M
    - 1001: 000, 100011, M
    - 1010: 001, 100011, M
    - 0110: 000, 010000, J
    - 0111: 000, 000000, N
  - any other opcode: trap_cause=01, go to TRAP
  - class N: instr_cnt+1, go to FETCH
  - other classes: go to EXEC
- EXEC:
  - alu_cont = alu_code, s = s_code for exactly one cycle
  - R: go to WB
  - M: go to MEM
  - J: pc_load=1 in this cycle, instr_cnt+1, go to FETCH
- MEM:
  - mem_req=1; alu_cont and s are held at the decoded values
  - mem_ready=1: go to WB and clear the timeout counter
  - else: increment the timeout counter; when it reaches all-ones with mem_ready still 0, set trap_cause=10 and go to TRAP
  - mem_ready=1 in the same cycle the counter reaches its limit: ready wins, no trap
- WB: reg_we=1 for one cycle, instr_cnt+1, go to FETCH. alu_cont and s return to 0 in WB.
- TRAP: trap=1, all strobes 0; only rst exits this state.
- Outside EXEC and MEM, alu_cont=0 and s=0.
- Latency per instruction, in cycles from the FETCH cycle:
  - R: 4
  - M: 5 plus memory wait cycles
  - J: 3
  - N: 2
- Halt asserted in any state other than FETCH is ignored until the next FETCH. The current instruction always retires.
- instr_cnt wraps from 2**CNT_W-1 to 0.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - class enum (R, M, J, N)
  - trap-cause constants
  - decode function mapping an opcode to {valid, class, alu, s}
- One sub-module, mc_decode: a combinational decode table wrapper over the package function. The FSM, timeout counter and instr_cnt stay in the top.

Test Plan:
- Reset, then opr=0000 with halt=0, mem_ready=0 -> ir_load at cycle 1; alu_cont=100, s=000100 at cycle 3; reg_we at cycle 4; instr_cnt=1.
- opr=1001 with mem_ready asserted on the 3rd MEM cycle -> mem_req held 3 cycles with s=100011 and alu_cont=000 held; reg_we follows; instr_cnt=1.
- opr=1000 with mem_ready=0 held -> after 15 MEM cycles (TMO_W=4): trap=1, trap_cause=10; stays in TRAP; rst returns to FETCH with all outputs 0.
- opr=0100 -> trap=1 and trap_cause=01 after DECODE; no reg_we, pc_load or mem_req ever pulses.
- halt raised during EXEC of a 0110 (jump) -> pc_load=1 and the jump retires; next FETCH enters HALTED with no ir_load; halt dropped -> FETCH resumes next cycle.
- Back-to-back stream 0111, 0110, 0011 with CNT_W=2, starting from instr_cnt=3 -> instr_cnt goes 0, 1, 2 (wraps); cycle totals 2, 3, 4.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and the opcode decode table for the multi-cycle controller.
package mc_pkg;

  localparam int unsigned DEC_OPC_W = 4;
  localparam int unsigned DEC_ALU_W = 3;
  localparam int unsigned DEC_SEL_W = 6;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CLS_R = 2'd0,
    CLS_M = 2'd1,
    CLS_J = 2'd2,
    CLS_N = 2'd3
  } cls_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic                 valid;
    cls_e                 cls;
    logic [DEC_ALU_W-1:0] alu;
    logic [DEC_SEL_W-1:0] s;
  } dec_t;

  // Maps the low opcode nibble to {valid, class, alu, s}.
  function automatic dec_t decode_op(input logic [DEC_OPC_W-1:0] op);
    dec_t d;
    d.valid = 1'b1;
    d.cls   = CLS_R;
    d.alu   = '0;
    d.s     = '0;
    case (op)
      4'b0000: begin d.alu = 3'b100; d.s = 6'b000100; end
      4'b0001: begin d.alu = 3'b011; d.s = 6'b001000; end
      4'b0010: begin d.alu = 3'b000; d.s = 6'b000100; end
      4'b0011: begin d.alu = 3'b001; d.s = 6'b000100; end
      4'b1000: begin d.cls = CLS_M; d.alu = 3'b011; d.s = 6'b100011; end
      4'b1001: begin d.cls = CLS_M; d.alu = 3'b000; d.s = 6'b100011; end
      4'b1010: begin d.cls = CLS_M; d.alu = 3'b001; d.s = 6'b100011; end
      4'b0110: begin d.cls = CLS_J; d.s = 6'b010000; end
      4'b0111: d.cls = CLS_N;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder; wide opcodes with any upper bit set are illegal.
module mc_decode
  import mc_pkg::*;
#(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned ALU_W = 3,
  parameter int unsigned SEL_W = 6
) (
  input  logic [OPC_W-1:0] opr,
  output logic             valid_c,
  output cls_e             cls_c,
  output logic [ALU_W-1:0] alu_c,
  output logic [SEL_W-1:0] s_c
);

  dec_t dec;
  logic hi_nz;

  always_comb begin
    hi_nz   = (opr >> DEC_OPC_W) != '0;
    dec     = decode_op(opr[DEC_OPC_W-1:0]);
    valid_c = dec.valid & ~hi_nz;
    cls_c   = dec.cls;
    alu_c   = ALU_W'(dec.alu);
    s_c     = SEL_W'(dec.s);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb with halt, traps
// and a retired-instruction counter. Outputs are registered from the current state.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned ALU_W = 3,
  parameter int unsigned SEL_W = 6,
  parameter int unsigned TMO_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opr,
  input  logic             halt,
  input  logic             mem_ready,
  output logic [ALU_W-1:0] alu_cont,
  output logic [SEL_W-1:0] s,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mem_req,
  output logic             reg_we,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [ALU_W-1:0] alu_code_q, alu_code_d;
  logic [SEL_W-1:0] s_code_q, s_code_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ALU_W-1:0] alu_cont_q, alu_cont_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic             ir_load_q, ir_load_d;
  logic             pc_inc_q, pc_inc_d;
  logic             pc_load_q, pc_load_d;
  logic             mem_req_q, mem_req_d;
  logic             reg_we_q, reg_we_d;
  logic             halted_q, halted_d;
  logic             trap_q, trap_d;
  logic [1:0]       trap_cause_q, trap_cause_d;

  logic             dec_valid_c;
  cls_e             dec_cls_c;
  logic [ALU_W-1:0] dec_alu_c;
  logic [SEL_W-1:0] dec_s_c;

  mc_decode #(
    .OPC_W(OPC_W),
    .ALU_W(ALU_W),
    .SEL_W(SEL_W)
  ) u_decode (
    .opr    (opr),
    .valid_c(dec_valid_c),
    .cls_c  (dec_cls_c),
    .alu_c  (dec_alu_c),
    .s_c    (dec_s_c)
  );

  // Next state, latched decode fields, counters and next registered outputs.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    alu_code_d   = alu_code_q;
    s_code_d     = s_code_q;
    tmo_d        = tmo_q;
    tmo_inc      = tmo_q + TMO_W'(1);
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    alu_cont_d   = '0;
    s_d          = '0;
    ir_load_d    = 1'b0;
    pc_inc_d     = 1'b0;
    pc_load_d    = 1'b0;
    mem_req_d    = 1'b0;
    reg_we_d     = 1'b0;
    halted_d     = 1'b0;
    trap_d       = 1'b0;
    trap_cause_d = CAUSE_NONE;

    case (state_q)
      ST_FETCH: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else begin
          ir_load_d = 1'b1;
          pc_inc_d  = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
        if (!halt) state_d = ST_FETCH;
      end
      ST_DECODE: begin
        alu_code_d = dec_alu_c;
        s_code_d   = dec_s_c;
        cls_d      = dec_cls_c;
        if (!dec_valid_c) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end else if (dec_cls_c == CLS_N) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_cont_d = alu_code_q;
        s_d        = s_code_q;
        case (cls_q)
          CLS_R:   state_d = ST_WB;
          CLS_M:   state_d = ST_MEM;
          default: begin
            pc_load_d = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        mem_req_d  = 1'b1;
        alu_cont_d = alu_code_q;
        s_d        = s_code_q;
        // Ready is checked first so a completion on the limit cycle still wins.
        if (mem_ready) begin
          tmo_d   = '0;
          state_d = ST_WB;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == '1) begin
            cause_d = CAUSE_TIMEOUT;
            state_d = ST_TRAP;
          end
        end
      end
      ST_WB: begin
        reg_we_d = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = ST_FETCH;
      end
      ST_TRAP: begin
        trap_d       = 1'b1;
        trap_cause_d = cause_q;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      cls_q        <= CLS_R;
      alu_code_q   <= '0;
      s_code_q     <= '0;
      tmo_q        <= '0;
      cause_q      <= CAUSE_NONE;
      cnt_q        <= '0;
      alu_cont_q   <= '0;
      s_q          <= '0;
      ir_load_q    <= 1'b0;
      pc_inc_q     <= 1'b0;
      pc_load_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      halted_q     <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      alu_code_q   <= alu_code_d;
      s_code_q     <= s_code_d;
      tmo_q        <= tmo_d;
      cause_q      <= cause_d;
      cnt_q        <= cnt_d;
      alu_cont_q   <= alu_cont_d;
      s_q          <= s_d;
      ir_load_q    <= ir_load_d;
      pc_inc_q     <= pc_inc_d;
      pc_load_q    <= pc_load_d;
      mem_req_q    <= mem_req_d;
      reg_we_q     <= reg_we_d;
      halted_q     <= halted_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign alu_cont   = alu_cont_q;
  assign s          = s_q;
  assign ir_load    = ir_load_q;
  assign pc_inc     = pc_inc_q;
  assign pc_load    = pc_load_q;
  assign mem_req    = mem_req_q;
  assign reg_we     = reg_we_q;
  assign halted     = halted_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a per-instruction timeline model.
module tb_multicycle_controller;

  localparam int unsigned TB_CNT_W = 2;

  logic                clk;
  logic                rst;
  logic [3:0]          opr;
  logic                halt;
  logic                mem_ready;
  logic [2:0]          alu_cont;
  logic [5:0]          s;
  logic                ir_load, pc_inc, pc_load, mem_req, reg_we, halted, trap;
  logic [1:0]          trap_cause;
  logic [TB_CNT_W-1:0] instr_cnt;

  int                  checks;
  int                  failures;
  logic [TB_CNT_W-1:0] exp_cnt;

  multicycle_controller #(
    .OPC_W(4), .ALU_W(3), .SEL_W(6), .TMO_W(4), .CNT_W(TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opr       (opr),
    .halt      (halt),
    .mem_ready (mem_ready),
    .alu_cont  (alu_cont),
    .s         (s),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mem_req   (mem_req),
    .reg_we    (reg_we),
    .halted    (halted),
    .trap      (trap),
    .trap_cause(trap_cause),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] observed();
    return {ir_load, pc_inc, pc_load, mem_req, reg_we, halted, trap,
            trap_cause, alu_cont, s, instr_cnt};
  endfunction

  // Reference decode table: cls 0=R 1=M 2=J 3=N.
  task automatic ref_decode(input logic [3:0] op, output bit ok, output int cls,
                            output logic [2:0] ra, output logic [5:0] rs);
    ok = 1'b1; cls = 0; ra = 3'b000; rs = 6'b000000;
    case (op)
      4'h0: begin ra = 3'b100; rs = 6'b000100; end
      4'h1: begin ra = 3'b011; rs = 6'b001000; end
      4'h2: begin ra = 3'b000; rs = 6'b000100; end
      4'h3: begin ra = 3'b001; rs = 6'b000100; end
      4'h8: begin cls = 1; ra = 3'b011; rs = 6'b100011; end
      4'h9: begin cls = 1; ra = 3'b000; rs = 6'b100011; end
      4'hA: begin cls = 1; ra = 3'b001; rs = 6'b100011; end
      4'h6: begin cls = 2; rs = 6'b010000; end
      4'h7: cls = 3;
      default: ok = 1'b0;
    endcase
  endtask

  function automatic logic [3:0] rand_legal();
    logic [3:0] tbl [9];
    tbl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'h6, 4'h7};
    return tbl[$urandom_range(0, 8)];
  endfunction

  // Runs one instruction starting in FETCH. w = MEM cycles without ready (>14 = never ready).
  // Cycle k is the output observed after the k-th edge, FETCH being evaluated at edge 1.
  task automatic run_instr(input logic [3:0] op, input int w, input bit force_halt);
    bit ok; int cls; logic [2:0] ra; logic [5:0] rs;
    int t_trap, last_k, mem_last, ready_k, ret_k;
    logic [1:0] cause;
    logic e_act, e_mreq, e_trap;
    logic [19:0] exp_v;
    ref_decode(op, ok, cls, ra, rs);
    t_trap = 0; ready_k = -1; mem_last = 0; ret_k = -1; cause = 2'b00; last_k = 2;
    if (!ok) begin
      t_trap = 3; cause = 2'b01; last_k = 8;
    end else begin
      case (cls)
        0: begin last_k = 4; ret_k = 4; end
        1: if (w > 14) begin
             mem_last = 18; t_trap = 19; cause = 2'b10; last_k = 23;
           end else begin
             mem_last = 4 + w; ready_k = 4 + w; last_k = 5 + w; ret_k = last_k;
           end
        2: begin last_k = 3; ret_k = 3; end
        default: begin last_k = 2; ret_k = 2; end
      endcase
    end
    for (int k = 1; k <= last_k; k++) begin
      halt = (k == 1) ? 1'b0 : ((force_halt && k >= 3) ? 1'b1 : 1'($urandom_range(0, 1)));
      opr  = (k == 2) ? op : 4'($urandom);
      if (ok && cls == 1 && k >= 4 && k <= mem_last) mem_ready = (k == ready_k);
      else mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (k == ret_k) exp_cnt = exp_cnt + 1'b1;
      e_act  = ok && (k == 3 || (cls == 1 && k >= 4 && k <= mem_last));
      e_mreq = ok && cls == 1 && k >= 4 && k <= mem_last;
      e_trap = (t_trap != 0) && (k >= t_trap);
      exp_v = {(k == 1), (k == 1), (ok && cls == 2 && k == 3), e_mreq,
               (ok && ((cls == 0 && k == 4) || (cls == 1 && k == ready_k + 1))),
               1'b0, e_trap, (e_trap ? cause : 2'b00),
               (e_act ? ra : 3'b000), (e_act ? rs : 6'b000000), exp_cnt};
      checks++;
      if (observed() !== exp_v) begin
        failures++;
        $display("FAIL instr op=%h w=%0d k=%0d got=%h exp=%h", op, w, k, observed(), exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
    opr = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    exp_cnt = '0;
    checks++;
    if (observed() !== 20'h0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", observed(), 20'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_r_type();
    run_instr(4'h0, 0, 1'b0);
  endtask

  task automatic test_mem_wait();
    run_instr(4'h9, 2, 1'b0);
    run_instr(4'hA, 14, 1'b0);
  endtask

  task automatic test_timeout();
    run_instr(4'h8, 15, 1'b0);
    test_reset();
  endtask

  task automatic test_illegal();
    logic [3:0] bad [7];
    bad = '{4'h4, 4'h5, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    run_instr(4'h4, 0, 1'b0);
    test_reset();
    run_instr(bad[$urandom_range(0, 6)], 0, 1'b0);
    test_reset();
  endtask

  task automatic test_reset_mid();
    run_instr(4'h3, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      halt = 1'b0; opr = 4'h8; mem_ready = 1'b0;
      @(posedge clk); #1;
    end
    test_reset();
  endtask

  task automatic test_halt();
    int h;
    logic [19:0] exp_v;
    run_instr(4'h6, 0, 1'b1);
    h = $urandom_range(2, 5);
    for (int k = 1; k <= h + 1; k++) begin
      halt = (k <= h); opr = 4'($urandom); mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      exp_v = {5'b0, (k >= 2), 1'b0, 2'b00, 3'b000, 6'b000000, exp_cnt};
      checks++;
      if (observed() !== exp_v) begin
        failures++;
        $display("FAIL halt k=%0d got=%h exp=%h", k, observed(), exp_v);
      end
    end
    run_instr(rand_legal(), $urandom_range(0, 3), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3];
    logic [TB_CNT_W-1:0] want [3];
    ops  = '{4'h7, 4'h6, 4'h3};
    want = '{2'd0, 2'd1, 2'd2};
    test_reset();
    for (int i = 0; i < 3; i++) run_instr(rand_legal(), $urandom_range(0, 2), 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_instr(ops[i], 0, 1'b0);
      checks++;
      if (instr_cnt !== want[i]) begin
        failures++;
        $display("FAIL b2b_cnt i=%0d got=%0d exp=%0d", i, instr_cnt, want[i]);
      end
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 6);
      run_instr(rand_legal(), w, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0; failures = 0; exp_cnt = '0;
    rst = 1'b1; halt = 1'b0; mem_ready = 1'b0; opr = 4'h0;
    test_reset();
    test_r_type();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_halt();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
